// File: rtl/game_flow_ctrl.sv
// Frame-level game sequencer: IDLE/RUN/PAUSE/OVER, lives, score, invulnerability window.
// Optional HIGH_SCORE_EN adds a high_score_o register kept across games.
module game_flow_ctrl #(
  parameter int LIVES_INIT       = 3,
  parameter int INVULN_FRAMES    = 120,
  parameter int OVER_HOLD_FRAMES = 180,
  parameter int SCORE_WIDTH      = 16,
  parameter int SCORE_PER_HIT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   v_sync_i,
  input  logic                   start_btn_i,
  input  logic                   pause_btn_i,
  input  logic                   crash_me_enemy_i,
  input  logic                   crash_enemy_bullet_i,
  output logic [1:0]             game_status_o,
  output logic                   run_en_o,
  output logic                   bomb_o,
  output logic                   invuln_o,
  output logic [3:0]             lives_o,
  output logic [SCORE_WIDTH-1:0] score_o
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_WIDTH-1:0] high_score_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [3:0]           LIVES_L  = 4'(LIVES_INIT);
  localparam logic [7:0]           INVULN_L = 8'(INVULN_FRAMES);
  localparam logic [7:0]           HOLD_L   = 8'(OVER_HOLD_FRAMES);
  localparam logic [SCORE_WIDTH:0] HIT_L    = (SCORE_WIDTH+1)'(SCORE_PER_HIT);

  state_e                 state_q, state_d;
  logic                   vs_q, vs_prev_q;
  logic                   start_q, start_prev_q;
  logic                   pause_q, pause_prev_q;
  logic [3:0]             lives_q, lives_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [7:0]             invuln_q, invuln_d;
  logic [7:0]             hold_q, hold_d;
  logic                   me_hit_q, me_hit_d;
  logic                   en_hit_q, en_hit_d;
  logic                   bomb_q, bomb_d;
  logic [1:0]             status_q, status_d;
  logic                   run_en_q, run_en_d;
  logic                   invuln_o_q, invuln_o_d;
`ifdef HIGH_SCORE_EN
  logic [SCORE_WIDTH-1:0] high_score_q;
`endif

  logic                   tick_s, start_edge_s, pause_edge_s;
  logic                   me_eff_s, en_eff_s;
  logic [SCORE_WIDTH:0]   score_sum_s;
  logic [SCORE_WIDTH-1:0] score_inc_s;

  assign tick_s       = vs_prev_q & ~vs_q;
  assign start_edge_s = start_q & ~start_prev_q;
  assign pause_edge_s = pause_q & ~pause_prev_q;
  // Flags include the current cycle's crash so a hit on the tick cycle is not lost.
  assign me_eff_s     = me_hit_q | ((state_q == ST_RUN) & crash_me_enemy_i);
  assign en_eff_s     = en_hit_q | ((state_q == ST_RUN) & crash_enemy_bullet_i);
  assign score_sum_s  = {1'b0, score_q} + HIT_L;
  assign score_inc_s  = score_sum_s[SCORE_WIDTH] ? {SCORE_WIDTH{1'b1}} : score_sum_s[SCORE_WIDTH-1:0];

  // State, game counters, input edge registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      pause_q      <= 1'b0;
      pause_prev_q <= 1'b0;
      lives_q      <= 4'd0;
      score_q      <= {SCORE_WIDTH{1'b0}};
      invuln_q     <= 8'd0;
      hold_q       <= 8'd0;
      me_hit_q     <= 1'b0;
      en_hit_q     <= 1'b0;
      bomb_q       <= 1'b0;
      status_q     <= 2'd0;
      run_en_q     <= 1'b0;
      invuln_o_q   <= 1'b0;
`ifdef HIGH_SCORE_EN
      high_score_q <= {SCORE_WIDTH{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      vs_q         <= v_sync_i;
      vs_prev_q    <= vs_q;
      start_q      <= start_btn_i;
      start_prev_q <= start_q;
      pause_q      <= pause_btn_i;
      pause_prev_q <= pause_q;
      lives_q      <= lives_d;
      score_q      <= score_d;
      invuln_q     <= invuln_d;
      hold_q       <= hold_d;
      me_hit_q     <= me_hit_d;
      en_hit_q     <= en_hit_d;
      bomb_q       <= bomb_d;
      status_q     <= status_d;
      run_en_q     <= run_en_d;
      invuln_o_q   <= invuln_o_d;
`ifdef HIGH_SCORE_EN
      if ((state_q == ST_RUN) && (state_d == ST_OVER) && (score_d > high_score_q)) begin
        high_score_q <= score_d;
      end
`endif
    end
  end

  // Next-state and game-counter update logic.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    score_d  = score_q;
    invuln_d = invuln_q;
    hold_d   = hold_q;
    me_hit_d = me_eff_s;
    en_hit_d = en_eff_s;
    bomb_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d  = ST_RUN;
          lives_d  = LIVES_L;
          score_d  = {SCORE_WIDTH{1'b0}};
          invuln_d = INVULN_L;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick_s) begin
          me_hit_d = 1'b0;
          en_hit_d = 1'b0;
          if (en_eff_s) begin
            score_d = score_inc_s;
          end else begin
            score_d = score_q;
          end
          if (me_eff_s && (invuln_q == 8'd0)) begin
            lives_d = lives_q - 4'd1;
            bomb_d  = 1'b1;
            if (lives_q == 4'd1) begin
              state_d = ST_OVER;
              hold_d  = 8'd0;
            end else begin
              invuln_d = INVULN_L;
            end
          end else if (invuln_q != 8'd0) begin
            invuln_d = invuln_q - 8'd1;
          end else begin
            invuln_d = invuln_q;
          end
        end else begin
          state_d = ST_RUN;
        end
        // The tick is resolved first; a game over overrides a simultaneous pause.
        if (pause_edge_s && (state_d == ST_RUN)) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = state_d;
        end
      end
      ST_PAUSE: begin
        if (pause_edge_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_OVER: begin
        if (tick_s && (hold_q != HOLD_L)) begin
          hold_d = hold_q + 8'd1;
        end else begin
          hold_d = hold_q;
        end
        if (start_edge_s && (hold_q == HOLD_L)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) begin
      me_hit_d = 1'b0;
      en_hit_d = 1'b0;
    end else begin
      me_hit_d = me_hit_d;
      en_hit_d = en_hit_d;
    end
  end

  // Output decode, registered one cycle behind the state.
  always_comb begin
    status_d   = state_q;
    run_en_d   = (state_q == ST_RUN);
    invuln_o_d = (invuln_q != 8'd0);
  end

  assign game_status_o = status_q;
  assign run_en_o      = run_en_q;
  assign bomb_o        = bomb_q;
  assign invuln_o      = invuln_o_q;
  assign lives_o       = lives_q;
  assign score_o       = score_q;
`ifdef HIGH_SCORE_EN
  assign high_score_o  = high_score_q;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default parameters.
// The HIGH_SCORE_EN scenario is compiled only when that macro is defined.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v_sync_i = 1'b0;
  logic        start_btn_i = 1'b0;
  logic        pause_btn_i = 1'b0;
  logic        crash_me_enemy_i = 1'b0;
  logic        crash_enemy_bullet_i = 1'b0;
  logic [1:0]  game_status_o;
  logic        run_en_o;
  logic        bomb_o;
  logic        invuln_o;
  logic [3:0]  lives_o;
  logic [15:0] score_o;
`ifdef HIGH_SCORE_EN
  logic [15:0] high_score_o;
`endif

  int checks = 0;
  int errors = 0;
  int bomb_cnt = 0;

  game_flow_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .v_sync_i             (v_sync_i),
    .start_btn_i          (start_btn_i),
    .pause_btn_i          (pause_btn_i),
    .crash_me_enemy_i     (crash_me_enemy_i),
    .crash_enemy_bullet_i (crash_enemy_bullet_i),
    .game_status_o        (game_status_o),
    .run_en_o             (run_en_o),
    .bomb_o               (bomb_o),
    .invuln_o             (invuln_o),
    .lives_o              (lives_o),
    .score_o              (score_o)
`ifdef HIGH_SCORE_EN
    ,
    .high_score_o         (high_score_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bomb_o) bomb_cnt++;
  end

  // One frame: optional one-cycle crash pulses, then a v_sync high/low cycle yielding one tick.
  task automatic frames(input int n, input logic me, input logic en);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      crash_me_enemy_i = me;
      crash_enemy_bullet_i = en;
      @(negedge clk);
      crash_me_enemy_i = 1'b0;
      crash_enemy_bullet_i = 1'b0;
      v_sync_i = 1'b1;
      repeat (2) @(negedge clk);
      v_sync_i = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic press_start();
    @(negedge clk);
    start_btn_i = 1'b1;
    repeat (3) @(negedge clk);
    start_btn_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_pause();
    @(negedge clk);
    pause_btn_i = 1'b1;
    repeat (3) @(negedge clk);
    pause_btn_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({game_status_o, run_en_o, bomb_o, invuln_o, lives_o, score_o} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0d run=%0b bomb=%0b inv=%0b lives=%0d score=%0d, expected all 0",
               game_status_o, run_en_o, bomb_o, invuln_o, lives_o, score_o);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({game_status_o, run_en_o, invuln_o, lives_o, score_o} !== 24'd0) begin
      errors++;
      $display("FAIL idle_after_release: got st=%0d run=%0b inv=%0b lives=%0d score=%0d, expected all 0",
               game_status_o, run_en_o, invuln_o, lives_o, score_o);
    end
  endtask

  task automatic test_start();
    press_start();
    checks++;
    if (game_status_o !== 2'd1 || run_en_o !== 1'b1 || lives_o !== 4'd3 || invuln_o !== 1'b1 || score_o !== 16'd0) begin
      errors++;
      $display("FAIL start: got st=%0d run=%0b lives=%0d inv=%0b score=%0d, expected 1 1 3 1 0",
               game_status_o, run_en_o, lives_o, invuln_o, score_o);
    end
  endtask

  task automatic test_score();
    @(negedge clk);
    v_sync_i = 1'b1;
    crash_enemy_bullet_i = 1'b1;
    repeat (50) @(negedge clk);
    crash_enemy_bullet_i = 1'b0;
    checks++;
    if (score_o !== 16'd0) begin
      errors++;
      $display("FAIL score_before_tick: got %0d, expected 0", score_o);
    end
    v_sync_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (score_o !== 16'd1) begin
      errors++;
      $display("FAIL score_one_per_frame: got %0d, expected 1", score_o);
    end
    frames(2, 1'b0, 1'b1);
    checks++;
    if (score_o !== 16'd3) begin
      errors++;
      $display("FAIL score_three_frames: got %0d, expected 3", score_o);
    end
  endtask

  task automatic test_invuln();
    frames(6, 1'b0, 1'b0);
    frames(1, 1'b1, 1'b0);
    checks++;
    if (lives_o !== 4'd3 || bomb_cnt !== 0) begin
      errors++;
      $display("FAIL invuln_protects: got lives=%0d bombs=%0d, expected 3 0", lives_o, bomb_cnt);
    end
    frames(109, 1'b0, 1'b0);
    checks++;
    if (invuln_o !== 1'b1) begin
      errors++;
      $display("FAIL invuln_tick119: got %0b, expected 1", invuln_o);
    end
    frames(1, 1'b0, 1'b0);
    checks++;
    if (invuln_o !== 1'b0) begin
      errors++;
      $display("FAIL invuln_tick120: got %0b, expected 0", invuln_o);
    end
    frames(1, 1'b1, 1'b0);
    checks++;
    if (lives_o !== 4'd2 || bomb_cnt !== 1 || invuln_o !== 1'b1 || game_status_o !== 2'd1) begin
      errors++;
      $display("FAIL life_lost: got lives=%0d bombs=%0d inv=%0b st=%0d, expected 2 1 1 1",
               lives_o, bomb_cnt, invuln_o, game_status_o);
    end
  endtask

  task automatic test_pause();
    frames(5, 1'b0, 1'b0);
    press_pause();
    checks++;
    if (game_status_o !== 2'd2 || run_en_o !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: got st=%0d run=%0b, expected 2 0", game_status_o, run_en_o);
    end
    frames(5, 1'b1, 1'b1);
    checks++;
    if (lives_o !== 4'd2 || score_o !== 16'd3 || bomb_cnt !== 1) begin
      errors++;
      $display("FAIL pause_frozen: got lives=%0d score=%0d bombs=%0d, expected 2 3 1", lives_o, score_o, bomb_cnt);
    end
    press_start();
    checks++;
    if (game_status_o !== 2'd2) begin
      errors++;
      $display("FAIL pause_ignores_start: got st=%0d, expected 2", game_status_o);
    end
    press_pause();
    checks++;
    if (game_status_o !== 2'd1 || run_en_o !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: got st=%0d run=%0b, expected 1 1", game_status_o, run_en_o);
    end
    frames(114, 1'b0, 1'b0);
    checks++;
    if (invuln_o !== 1'b1) begin
      errors++;
      $display("FAIL invuln_resume_last: got %0b, expected 1", invuln_o);
    end
    frames(1, 1'b0, 1'b0);
    checks++;
    if (invuln_o !== 1'b0 || lives_o !== 4'd2) begin
      errors++;
      $display("FAIL invuln_resume_end: got inv=%0b lives=%0d, expected 0 2", invuln_o, lives_o);
    end
  endtask

  task automatic test_over();
    frames(1, 1'b1, 1'b0);
    frames(120, 1'b0, 1'b0);
    frames(1, 1'b1, 1'b1);
    checks++;
    if (game_status_o !== 2'd3 || run_en_o !== 1'b0 || lives_o !== 4'd0 || score_o !== 16'd4 || bomb_cnt !== 3) begin
      errors++;
      $display("FAIL game_over: got st=%0d run=%0b lives=%0d score=%0d bombs=%0d, expected 3 0 0 4 3",
               game_status_o, run_en_o, lives_o, score_o, bomb_cnt);
    end
    frames(100, 1'b0, 1'b0);
    press_start();
    checks++;
    if (game_status_o !== 2'd3) begin
      errors++;
      $display("FAIL over_hold100: got st=%0d, expected 3", game_status_o);
    end
    frames(79, 1'b0, 1'b0);
    press_start();
    checks++;
    if (game_status_o !== 2'd3) begin
      errors++;
      $display("FAIL over_hold179: got st=%0d, expected 3", game_status_o);
    end
    frames(1, 1'b0, 1'b0);
    press_start();
    checks++;
    if (game_status_o !== 2'd0 || lives_o !== 4'd0 || score_o !== 16'd4) begin
      errors++;
      $display("FAIL over_to_idle: got st=%0d lives=%0d score=%0d, expected 0 0 4", game_status_o, lives_o, score_o);
    end
    press_start();
    checks++;
    if (game_status_o !== 2'd1 || lives_o !== 4'd3 || score_o !== 16'd0 || invuln_o !== 1'b1) begin
      errors++;
      $display("FAIL restart: got st=%0d lives=%0d score=%0d inv=%0b, expected 1 3 0 1",
               game_status_o, lives_o, score_o, invuln_o);
    end
  endtask

  task automatic test_async_reset();
    frames(7, 1'b0, 1'b1);
    checks++;
    if (score_o !== 16'd7) begin
      errors++;
      $display("FAIL score_seven: got %0d, expected 7", score_o);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({game_status_o, run_en_o, bomb_o, invuln_o, lives_o, score_o} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d run=%0b bomb=%0b inv=%0b lives=%0d score=%0d, expected all 0",
               game_status_o, run_en_o, bomb_o, invuln_o, lives_o, score_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef HIGH_SCORE_EN
  task automatic lose_all();
    for (int i = 0; i < 3; i++) begin
      frames(120, 1'b0, 1'b0);
      frames(1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_high_score();
    checks++;
    if (high_score_o !== 16'd0) begin
      errors++;
      $display("FAIL high_score_reset: got %0d, expected 0", high_score_o);
    end
    press_start();
    frames(7, 1'b0, 1'b1);
    lose_all();
    checks++;
    if (game_status_o !== 2'd3 || high_score_o !== 16'd7) begin
      errors++;
      $display("FAIL high_score_first: got st=%0d hs=%0d, expected 3 7", game_status_o, high_score_o);
    end
    frames(180, 1'b0, 1'b0);
    press_start();
    press_start();
    frames(4, 1'b0, 1'b1);
    lose_all();
    checks++;
    if (game_status_o !== 2'd3 || score_o !== 16'd4 || high_score_o !== 16'd7) begin
      errors++;
      $display("FAIL high_score_kept: got st=%0d score=%0d hs=%0d, expected 3 4 7",
               game_status_o, score_o, high_score_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_score();
    test_invuln();
    test_pause();
    test_over();
    test_async_reset();
`ifdef HIGH_SCORE_EN
    test_high_score();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Frame-level game sequencer for the plane-war datapath. It runs the IDLE/RUN/PAUSE/OVER state machine and tracks lives, score and the post-hit invulnerability window. It collapses the per-pixel crash levels from the collision logic into at most one event per frame. Its outputs gate the sprite movers (run enable), drive game status and the bomb pulse, and feed the score display.

Parameters:
LIVES_INIT, 3, lives loaded on game start; 1..15.
INVULN_FRAMES, 120, frames of invulnerability after start and after each life lost; 1..255.
OVER_HOLD_FRAMES, 180, minimum frames in OVER before start is accepted; 1..255.
SCORE_WIDTH, 16, score counter width.
SCORE_PER_HIT, 1, added per frame containing an enemy/bullet crash.

Ports:
clk  in  1  pixel clock, same domain as the VGA timing (clk_vga).
rst  in  1  asynchronous, active-low reset.
v_sync_i  in  1  VGA vertical sync from the display controller.
start_btn_i  in  1  debounced start level.
pause_btn_i  in  1  debounced pause level.
crash_me_enemy_i  in  1  per-pixel overlap level, player vs enemy.
crash_enemy_bullet_i  in  1  per-pixel overlap level, enemy vs bullet.
game_status_o  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=OVER.
run_en_o  out  1  high only in RUN.
bomb_o  out  1  one-cycle pulse on life lost.
invuln_o  out  1  high while the invulnerability count is nonzero.
lives_o  out  4  remaining lives.
score_o  out  SCORE_WIDTH  current score.

Behaviour:
- Reset (rst=0, async): state IDLE, game_status_o=0, run_en_o=0, bomb_o=0, invuln_o=0, lives_o=0, score_o=0, all counters, flags and edge registers cleared.
- Frame tick: v_sync_i is registered once. tick is asserted for exactly one clk cycle, in the cycle after a 1->0 transition is sampled.
- Button edges: each button is registered once; an event is the 0->1 transition only. Held buttons do not repeat.
- Sticky flags me_hit and en_hit: in RUN, each is set on any cycle its crash input is 1. Both are cleared on every tick after being consumed, and on every state change.
- IDLE -> RUN on start edge: lives=LIVES_INIT, score=0, invuln=INVULN_FRAMES, flags cleared.
- RUN, on a tick, with all actions in the same cycle:
  - If en_hit: score += SCORE_PER_HIT, saturating at all-ones.
  - If me_hit and invuln==0: lives-1 and bomb_o pulses.
    - If lives was 1: lives=0 and go to OVER, with the hold counter set to 0.
    - Otherwise: invuln=INVULN_FRAMES.
  - Else, if invuln!=0: invuln-1.
- Score and life loss on the same tick are both applied; the score is updated even when that tick enters OVER.
- RUN -> PAUSE on pause edge. A pause edge and a tick in the same cycle: the tick is processed first, then the pause is taken. If the tick entered OVER, OVER wins and the pause is ignored.
- PAUSE: crash inputs are ignored, invuln and score are frozen, ticks are ignored. A pause edge returns to RUN. A start edge is ignored.
- OVER: run_en_o=0. The hold counter increments on each tick and saturates at OVER_HOLD_FRAMES. A start edge with hold==OVER_HOLD_FRAMES goes to IDLE; an earlier start edge is ignored. Score and lives are held until the next IDLE->RUN.
- A start edge in RUN or PAUSE is ignored.
- game_status_o, run_en_o and invuln_o are registered, so they change one cycle after the state transition.

Optional Feature:
HIGH_SCORE_EN: when defined, adds output port high_score_o (SCORE_WIDTH, reset 0). On the cycle of the RUN->OVER transition, high_score_o is loaded with the final score if that score is greater than high_score_o; a game reset does not clear it, only rst does. When undefined, the port and its register are absent.

Test Plan:
- Reset, then release rst with no stimulus → all outputs 0 and state IDLE; a start edge → status=1, lives=3, invuln_o=1 on the next cycle.
- Hold crash_enemy_bullet_i high for 50 cycles within one frame → score rises by exactly 1 at the tick; 3 consecutive frames with hits → score=3.
- Player crash at frame 10 after start (invuln active) → no life lost. Crash at frame 121 → lives=2, one bomb_o pulse, invuln_o high again for 120 ticks.
- Lose 3 lives → status=3 on the third loss. A start edge at 100 ticks → stays OVER. A start edge after 180 ticks → IDLE; a further start edge → score=0, lives=3.
- Pause edge in RUN → status=2; crash inputs held for 5 frames → lives and score unchanged. A pause edge → RUN, and invuln resumes from its frozen value.
- Assert rst mid-RUN with score=7 → all outputs 0 immediately, without waiting for a clk edge. With HIGH_SCORE_EN, a game over at score 7 then one at score 4 → high_score_o=7.
